stopwatch_data_gen: RTL and testbench

Upstream data source for the four-digit 74HC595 seven-segment display path: a signed centisecond stopwatch that produces `data`, `point`, `seg_en` and `sign` for the dynamic-scan driver, so the display shows ±00.00 to ±99.99 s. It is a drop-in alternative to the free-running data generator. It adds run/stop, clear and direction control from already-debounced single-cycle key pulses. All outputs are registered; the scan driver consumes them unchanged.

---
 rtl/seg_pkg.sv | 14 +
 rtl/tick_gen.sv | 32 +++
 rtl/stopwatch_data_gen.sv | 105 ++++++++++
 tb/tb_stopwatch_data_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the four-digit seven-segment display path.
package seg_pkg;

    localparam int unsigned DATA_W           = 14;
    localparam int unsigned DIGITS           = 4;
    localparam logic [3:0]  POINT_CENTI      = 4'b0100;
    localparam int unsigned DATA_MAX_DEFAULT = 9999;

    typedef enum logic [0:0] {
        StStop,
        StRun
    } run_state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts while enabled and pulses tick for one cycle when it wraps.
module tick_gen #(
    parameter int unsigned CNT_TICK_MAX = 499_999
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CNT_TICK_MAX > 0) ? $clog2(CNT_TICK_MAX + 1) : 1;

    logic [CW-1:0] cnt;
    logic          at_max;

    assign at_max = (cnt == CW'(CNT_TICK_MAX));

    // Decoded from the registered count, so it is clean for one full cycle.
    assign tick = en && !clr && at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_max ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/stopwatch_data_gen.sv
// Signed centisecond stopwatch feeding the seven-segment scan driver with
// run/stop, clear and direction control.
module stopwatch_data_gen
    import seg_pkg::*;
#(
    parameter int unsigned CNT_TICK_MAX = 499_999,
    parameter int unsigned DATA_MAX     = DATA_MAX_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start_stop,
    input  logic              clr,
    input  logic              dir,
    output logic [DATA_W-1:0] data,
    output logic [DIGITS-1:0] point,
    output logic              seg_en,
    output logic              sign,
    output logic              running
);

    localparam logic [DATA_W-1:0] MAG_MAX = DATA_W'(DATA_MAX);

    run_state_e        state;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] mag_next;
    logic              sign_next;
    logic              sat;
    logic              tick;
    logic              prescale_clr;

    // Restarting the prescaler on every stop->run edge gives a full first interval.
    assign prescale_clr = clr || (start_stop && (state == StStop));

    tick_gen #(
        .CNT_TICK_MAX(CNT_TICK_MAX)
    ) u_tick_gen (
        .clk (sys_clk),
        .rst (sys_rst),
        .en  (state == StRun),
        .clr (prescale_clr),
        .tick(tick)
    );

    always_comb begin
        mag_next  = mag;
        sign_next = sign;
        sat       = 1'b0;
        if (!dir) begin
            if (!sign) begin
                if (mag == MAG_MAX) sat = 1'b1;
                else                mag_next = mag + DATA_W'(1);
            end else begin
                mag_next = mag - DATA_W'(1);
                if (mag == DATA_W'(1)) sign_next = 1'b0;
            end
        end else begin
            if (sign) begin
                if (mag == MAG_MAX) sat = 1'b1;
                else                mag_next = mag + DATA_W'(1);
            end else if (mag == '0) begin
                sign_next = 1'b1;
                mag_next  = DATA_W'(1);
            end else begin
                mag_next = mag - DATA_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= StStop;
            mag    <= '0;
            sign   <= 1'b0;
            point  <= '0;
            seg_en <= 1'b0;
        end else begin
            point  <= POINT_CENTI;
            seg_en <= 1'b1;
            if (clr) begin
                state <= StStop;
                mag   <= '0;
                sign  <= 1'b0;
            end else begin
                if (tick) begin
                    mag  <= mag_next;
                    sign <= sign_next;
                end
                unique case (state)
                    StStop: begin
                        if (start_stop) state <= StRun;
                    end
                    StRun: begin
                        // A saturating tick stops the run first; start_stop then toggles.
                        if (tick && sat) state <= start_stop ? StRun : StStop;
                        else if (start_stop) state <= StStop;
                    end
                endcase
            end
        end
    end

    assign data    = mag;
    assign running = (state == StRun);

endmodule

// File: tb/tb_stopwatch_data_gen.sv
// Directed bench for stopwatch_data_gen with a four-clock tick.
module tb_stopwatch_data_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start_stop = 1'b0;
    logic        clr = 1'b0;
    logic        dir = 1'b0;
    logic [13:0] data, data2;
    logic [3:0]  point, point2;
    logic        seg_en, seg_en2;
    logic        sign, sign2;
    logic        running, running2;

    int total = 0;
    int bad = 0;

    always #5 sys_clk = ~sys_clk;

    stopwatch_data_gen #(
        .CNT_TICK_MAX(3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start_stop(start_stop),
        .clr       (clr),
        .dir       (dir),
        .data      (data),
        .point     (point),
        .seg_en    (seg_en),
        .sign      (sign),
        .running   (running)
    );

    // Small-limit copy to reach negative saturation quickly.
    stopwatch_data_gen #(
        .CNT_TICK_MAX(3),
        .DATA_MAX    (15)
    ) dut_small (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start_stop(start_stop),
        .clr       (clr),
        .dir       (dir),
        .data      (data2),
        .point     (point2),
        .seg_en    (seg_en2),
        .sign      (sign2),
        .running   (running2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cycles(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
    endtask

    int exp_mag[5] = '{1, 0, 1, 2, 3};
    int exp_sgn[5] = '{0, 0, 1, 1, 1};

    initial begin
        // Reset and fixed outputs
        cycles(5);
        check("rst_data", data, 0);
        check("rst_sign", sign, 0);
        check("rst_point", point, 0);
        check("rst_seg_en", seg_en, 0);
        check("rst_running", running, 0);
        sys_rst = 1'b0;
        cycles(1);
        check("post_rst_seg_en", seg_en, 1);
        check("post_rst_point", point, 4'b0100);
        check("post_rst_data", data, 0);
        check("post_rst_running", running, 0);

        // Count up, first-tick latency, stop
        dir = 1'b0;
        pulse_ss();
        check("start_running", running, 1);
        cycles(3);
        check("pre_tick_data", data, 0);
        cycles(1);
        check("first_tick_data", data, 1);
        cycles(36);
        check("up_data", data, 10);
        check("up_sign", sign, 0);
        pulse_ss();
        check("stop_running", running, 0);
        cycles(8);
        check("frozen_data", data, 10);

        // Zero crossing 2 -> -3
        pulse_clr();
        check("clr_data", data, 0);
        check("clr_running", running, 0);
        pulse_ss();
        cycles(8);
        check("preload_2", data, 2);
        dir = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycles(4);
            check($sformatf("cross_data_%0d", i), data, exp_mag[i]);
            check($sformatf("cross_sign_%0d", i), sign, exp_sgn[i]);
        end

        // clr together with start_stop at 57
        pulse_clr();
        dir = 1'b0;
        pulse_ss();
        cycles(228);
        check("at_57", data, 57);
        clr = 1'b1;
        start_stop = 1'b1;
        cycles(1);
        clr = 1'b0;
        start_stop = 1'b0;
        check("clr_ss_data", data, 0);
        check("clr_ss_sign", sign, 0);
        check("clr_ss_running", running, 0);
        cycles(8);
        check("clr_ss_hold", data, 0);

        // Mid-count reset at -12
        dir = 1'b1;
        pulse_ss();
        cycles(48);
        check("at_m12_data", data, 12);
        check("at_m12_sign", sign, 1);
        cycles(2);
        sys_rst = 1'b1;
        cycles(1);
        check("mid_rst_data", data, 0);
        check("mid_rst_sign", sign, 0);
        check("mid_rst_running", running, 0);
        check("mid_rst_seg_en", seg_en, 0);
        sys_rst = 1'b0;
        cycles(12);
        check("after_rst_data", data, 0);
        check("after_rst_running", running, 0);
        check("after_rst_seg_en", seg_en, 1);

        // Negative saturation on the small-limit instance
        pulse_clr();
        dir = 1'b1;
        pulse_ss();
        cycles(60);
        check("neg_pre_data", data2, 15);
        check("neg_pre_sign", sign2, 1);
        check("neg_pre_running", running2, 1);
        cycles(4);
        check("neg_sat_data", data2, 15);
        check("neg_sat_sign", sign2, 1);
        check("neg_sat_running", running2, 0);
        check("neg_main_data", data, 16);
        check("neg_main_running", running, 1);

        // Positive saturation at 9999
        pulse_clr();
        dir = 1'b0;
        pulse_ss();
        cycles(4 * 9999);
        check("pos_pre_data", data, 9999);
        check("pos_pre_running", running, 1);
        cycles(4);
        check("pos_sat_data", data, 9999);
        check("pos_sat_sign", sign, 0);
        check("pos_sat_running", running, 0);
        cycles(8);
        check("pos_sat_hold", data, 9999);
        pulse_ss();
        check("resat_running", running, 1);
        cycles(4);
        check("resat_stop", running, 0);
        check("resat_data", data, 9999);
        check("small_pos_data", data2, 15);
        check("small_pos_sign", sign2, 0);
        check("small_pos_running", running2, 0);
        check("small_point", point2, 4'b0100);
        check("small_seg_en", seg_en2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
